// File: rtl/xdisp_ctrl.sv
// xdisp_ctrl: bus-mapped binary to multiplexed 7-segment display controller.
// Values are converted to BCD by an iterative double-dabble engine, then shown via shadow registers.
module xdisp_ctrl #(
  parameter int DATA_W      = 32,
  parameter int DIGITS      = 4,
  parameter int BIN_W       = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic [DIGITS-1:0] disp_sel,
  output logic [7:0]        disp_value
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int CTRL_W = 4 + DIGITS;
  localparam int CNT_W  = $clog2(BIN_W);
  localparam int IDX_W  = $clog2(DIGITS);
  localparam int RC_W   = $clog2(REFRESH_DIV);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [BIN_W-1:0]  val_latch;
  logic [BIN_W-1:0]  shift_bin;
  logic [BCD_W-1:0]  bcd_work;
  logic              ovf_work;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_next;
  logic              shifted_out;

  logic [BCD_W-1:0]  shadow_bcd;
  logic              shadow_ovf;
  logic [BIN_W-1:0]  shadow_bin;
  logic [CTRL_W-1:0] ctrl_reg;

  logic [RC_W-1:0]   rcnt;
  logic [RC_W-1:0]   rcnt_next;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_next;

  logic [DIGITS-1:0] lead_zero;
  logic [3:0]        nib;
  logic [6:0]        seg;
  logic              dp_n;
  int                pos;

  logic              wr_value;
  logic              wr_ctrl;
  logic [1:0]        ctrl_msg;
  logic              ctrl_sgn;
  logic              ctrl_blank;
  logic [DIGITS-1:0] ctrl_dot;

  assign wr_value   = sel & we & (addr == 2'd0);
  assign wr_ctrl    = sel & we & (addr == 2'd1);
  assign busy       = (state != ST_IDLE);
  assign ctrl_msg   = ctrl_reg[1:0];
  assign ctrl_sgn   = ctrl_reg[2];
  assign ctrl_blank = ctrl_reg[3];
  assign ctrl_dot   = ctrl_reg[CTRL_W-1:4];

  function automatic logic [6:0] digit_code(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'd0:    c = 7'h40;
      4'd1:    c = 7'h79;
      4'd2:    c = 7'h24;
      4'd3:    c = 7'h30;
      4'd4:    c = 7'h19;
      4'd5:    c = 7'h12;
      4'd6:    c = 7'h02;
      4'd7:    c = 7'h78;
      4'd8:    c = 7'h00;
      4'd9:    c = 7'h10;
      default: c = 7'h7F;
    endcase
    return c;
  endfunction

  // Text messages are right-aligned; positions beyond the message stay dark.
  function automatic logic [6:0] msg_code(input logic [1:0] m, input int p);
    logic [6:0] c;
    c = 7'h7F;
    case (m)
      2'b01: begin
        if (p == 1)      c = 7'h40;
        else if (p == 0) c = 7'h0C;
      end
      2'b10: begin
        if (p == 2)      c = 7'h41;
        else if (p == 1) c = 7'h08;
        else if (p == 0) c = 7'h47;
      end
      2'b11: begin
        if (p == 2)      c = 7'h06;
        else if (p == 1) c = 7'h2F;
        else if (p == 0) c = 7'h2F;
      end
      default: c = 7'h7F;
    endcase
    return c;
  endfunction

  // One double-dabble step: add-3 correction on every nibble, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd_work;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_adj[d*4 +: 4] >= 4'd5)
        bcd_adj[d*4 +: 4] = bcd_adj[d*4 +: 4] + 4'd3;
    end
    shifted_out = bcd_adj[BCD_W-1];
    bcd_next    = {bcd_adj[BCD_W-2:0], shift_bin[BIN_W-1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      val_latch  <= '0;
      shift_bin  <= '0;
      bcd_work   <= '0;
      ovf_work   <= 1'b0;
      shadow_bcd <= '0;
      shadow_ovf <= 1'b0;
      shadow_bin <= '0;
    end else if (wr_value) begin
      state     <= ST_SHIFT;
      cnt       <= '0;
      val_latch <= data_in[BIN_W-1:0];
      shift_bin <= data_in[BIN_W-1:0];
      bcd_work  <= '0;
      ovf_work  <= 1'b0;
    end else begin
      case (state)
        ST_SHIFT: begin
          bcd_work  <= bcd_next;
          shift_bin <= {shift_bin[BIN_W-2:0], 1'b0};
          ovf_work  <= ovf_work | shifted_out;
          if (cnt == CNT_W'(BIN_W-1))
            state <= ST_LOAD;
          else
            cnt <= cnt + CNT_W'(1);
        end
        ST_LOAD: begin
          shadow_bcd <= bcd_work;
          shadow_ovf <= ovf_work;
          shadow_bin <= val_latch;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ctrl_reg <= '0;
    else if (wr_ctrl)
      ctrl_reg <= data_in[CTRL_W-1:0];
  end

  always_comb begin
    data_out = '0;
    if (sel) begin
      case (addr)
        2'd0:    data_out = DATA_W'(shadow_bin);
        2'd1:    data_out = DATA_W'(ctrl_reg);
        2'd2:    data_out = DATA_W'({shadow_ovf, busy});
        default: data_out = '0;
      endcase
    end
  end

  always_comb begin
    rcnt_next = rcnt + RC_W'(1);
    idx_next  = idx;
    if (rcnt == RC_W'(REFRESH_DIV-1)) begin
      rcnt_next = '0;
      idx_next  = (idx == IDX_W'(DIGITS-1)) ? '0 : idx + IDX_W'(1);
    end
  end

  // lead_zero[i] is set when every nibble from i up to the top digit is zero.
  always_comb begin
    lead_zero = '0;
    lead_zero[DIGITS-1] = (shadow_bcd[BCD_W-1 -: 4] == 4'd0);
    for (int i = DIGITS-2; i >= 0; i--)
      lead_zero[i] = lead_zero[i+1] & (shadow_bcd[i*4 +: 4] == 4'd0);
  end

  // Segment pattern for the digit that becomes selected on the coming edge.
  always_comb begin
    pos  = int'(idx_next);
    nib  = shadow_bcd[{idx_next, 2'b00} +: 4];
    dp_n = ~ctrl_dot[idx_next];
    seg  = 7'h7F;
    if (ctrl_msg != 2'b00)
      seg = msg_code(ctrl_msg, pos);
    else if (shadow_ovf)
      seg = 7'h3F;
    else if (ctrl_sgn && (idx_next == IDX_W'(DIGITS-1)))
      seg = 7'h3F;
    else if (ctrl_blank && (idx_next != '0) && lead_zero[idx_next])
      seg = 7'h7F;
    else
      seg = digit_code(nib);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt       <= '0;
      idx        <= '0;
      disp_sel   <= ~DIGITS'(1);
      disp_value <= 8'hC0;
    end else begin
      rcnt       <= rcnt_next;
      idx        <= idx_next;
      disp_sel   <= ~(DIGITS'(1) << idx_next);
      disp_value <= {dp_n, seg};
    end
  end

endmodule
